reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer on the back-end side of the rename/retire interface.
- Rename allocates one entry per cycle at the tail and reads the tail pointer and full flag.
- Execution units mark entries complete by ROB address.
- The block retires at most one completed entry per cycle from the head: it emits retire_en and retire_rob_addr, returns the superseded physical register to the free list, and raises a precise exception when the head entry faulted.

Parameters:
ROB_DEPTH, 16, number of entries; power of two, at least 4
PHY_RF_DEPTH, 64, physical register count; PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH)
ROB_ADDR_WIDTH, $clog2(ROB_DEPTH), entry index width (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  branch mispredict; discard all entries
alloc_en  in  1  allocate one entry at tail (rename's rob_incr_tail_ptr)
alloc_has_rd  in  1  instruction writes a destination register
alloc_old_phy_rd  in  PHY_RF_ADDR_WIDTH  previous mapping of rd; freed on retire
alloc_new_phy_rd  in  PHY_RF_ADDR_WIDTH  newly mapped physical rd
rob_tail_ptr  out  ROB_ADDR_WIDTH  index the next allocation will use
rob_full  out  1  count == ROB_DEPTH
rob_empty  out  1  count == 0
rob_count  out  ROB_ADDR_WIDTH+1  occupied entries
cpl_en  in  1  completion strobe
cpl_rob_addr  in  ROB_ADDR_WIDTH  completing entry
cpl_exception  in  1  completing instruction faulted
retire_en  out  1  one-cycle retire strobe
retire_rob_addr  out  ROB_ADDR_WIDTH  retired entry index
free_reg_en  out  1  return a register to the free list
free_reg_addr  out  PHY_RF_ADDR_WIDTH  register being freed
exception_out  out  1  head entry faulted; pipeline flush request
exception_rob_addr  out  ROB_ADDR_WIDTH  faulting entry index

Behaviour:
- State:
  - Per entry: valid, done, exc, has_rd, old_phy_rd, new_phy_rd.
  - head and tail pointers, ROB_ADDR_WIDTH wide, wrapping modulo ROB_DEPTH.
  - count register, ROB_ADDR_WIDTH+1 wide.
- Reset (rst=1 at an edge): all valid=0, head=tail=count=0, all registered outputs 0. Reset overrides every other input, including mid-stream.
- Derived outputs:
  - rob_full, rob_empty, rob_count and rob_tail_ptr come from registered state only; no combinational input-to-output paths.
- Allocation: if alloc_en && !rob_full at an edge:
  - Write entry[tail] with valid=1, done=0, exc=0, has_rd and both register fields.
  - tail increments.
  - alloc_en while rob_full is ignored, even if a retire happens at the same edge.
- Completion: if cpl_en and entry[cpl_rob_addr].valid, set done=1 and exc=cpl_exception.
  - Completion to an invalid entry is ignored.
  - Completion to the entry being retired at the same edge is ignored.
- Retire decision, each cycle from registered state, when entry[head].valid && entry[head].done:
  - exc=0 (normal retire):
    - At the next edge register retire_en=1 and retire_rob_addr=head.
    - Register free_reg_en=has_rd and free_reg_addr=old_phy_rd.
    - Clear valid; head increments.
  - exc=1 (exception):
    - At the next edge register exception_out=1, exception_rob_addr=head, retire_en=0.
    - If has_rd, register free_reg_en=1 with free_reg_addr=new_phy_rd.
    - Clear all entries; head=tail=count=0.
- Retire outputs are one-cycle pulses, 0 otherwise.
- Latency: cpl_en sampled at edge k on the head entry causes retire_en high during cycle k+1..k+2, i.e. one cycle after the done bit is visible. Sustained throughput is one retire per cycle.
- count update: +1 on an accepted alloc, -1 on a normal retire, unchanged when both occur at the same edge.
- flush at an edge:
  - Clear all valid bits; head=tail=count=0.
  - Suppress alloc, completion and any retire decided for that edge; retire/free/exception outputs are 0 the following cycle.
  - Exception retire and flush at the same edge are equivalent; no double free.
- Priority, highest first: rst > flush > exception retire > {normal retire, alloc, completion}. The items in braces are concurrent.
- Wrap-around: pointers wrap from ROB_DEPTH-1 to 0. Full and empty are disambiguated by count, not by pointer equality.

Test Plan:
- Reset, then allocate 3 entries (old_phy_rd 5,6,7; has_rd=1) -> rob_tail_ptr=3, rob_count=3, rob_empty=0, no retire_en.
- Complete entries 2,1,0 on consecutive cycles -> retire_en pulses in order for addr 0,1,2 on consecutive cycles after entry 0 completes, with free_reg_addr 5,6,7; rob_count reaches 0.
- Allocate 16 entries -> rob_full=1. A 17th alloc_en is ignored (tail stays 0). Complete entry 0 and keep alloc_en high -> entry 0 retires and count becomes 15, then the next alloc is accepted at index 0 with rob_full=1 again.
- Allocate 4 entries, complete entry 1 with cpl_exception=1, then complete entry 0 -> entry 0 retires normally. Next cycle: exception_out=1, exception_rob_addr=1, free_reg_addr=entry 1 new_phy_rd, retire_en=0; then rob_count=0, tail=0.
- With 5 entries, entry 0 done, assert flush together with alloc_en and cpl_en -> no retire_en next cycle, rob_count=0, rob_tail_ptr=0.
- Run 40 alloc/complete/retire cycles with immediate completion -> correct wrap-around of head and tail through index 15 to 0, in-order retire_rob_addr sequence, count never exceeds 16.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at the tail, marks entries complete by address, and retires from the head.
// Latency: a head completion at edge k retires at edge k+1. Registered outputs last one cycle. Up to one retire per cycle.
// Backpressure: rob_full blocks allocation. A retire at the same edge does not unblock it, so rename must watch rob_full.
module reorder_buffer #(
    parameter  int ROB_DEPTH         = 16,
    parameter  int PHY_RF_DEPTH      = 64,
    localparam int ROB_ADDR_WIDTH    = $clog2(ROB_DEPTH),
    localparam int PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc_en,
    input  logic                         alloc_has_rd,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] alloc_old_phy_rd,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] alloc_new_phy_rd,
    output logic [ROB_ADDR_WIDTH-1:0]    rob_tail_ptr,
    output logic                         rob_full,
    output logic                         rob_empty,
    output logic [ROB_ADDR_WIDTH:0]      rob_count,
    input  logic                         cpl_en,
    input  logic [ROB_ADDR_WIDTH-1:0]    cpl_rob_addr,
    input  logic                         cpl_exception,
    output logic                         retire_en,
    output logic [ROB_ADDR_WIDTH-1:0]    retire_rob_addr,
    output logic                         free_reg_en,
    output logic [PHY_RF_ADDR_WIDTH-1:0] free_reg_addr,
    output logic                         exception_out,
    output logic [ROB_ADDR_WIDTH-1:0]    exception_rob_addr
);

    typedef struct packed {
        logic                         valid;
        logic                         done;
        logic                         exc;
        logic                         has_rd;
        logic [PHY_RF_ADDR_WIDTH-1:0] old_phy_rd;
        logic [PHY_RF_ADDR_WIDTH-1:0] new_phy_rd;
    } rob_entry_t;

    localparam logic [ROB_ADDR_WIDTH:0] FULL_CNT = (ROB_ADDR_WIDTH+1)'(ROB_DEPTH);

    rob_entry_t                  entries [ROB_DEPTH];
    logic [ROB_ADDR_WIDTH-1:0]   head;
    logic [ROB_ADDR_WIDTH-1:0]   tail;
    logic [ROB_ADDR_WIDTH:0]     count;

    logic head_rdy;
    logic norm_retire;
    logic exc_retire;
    logic alloc_acc;
    logic cpl_acc;

    assign rob_tail_ptr = tail;
    assign rob_count    = count;
    assign rob_full     = (count == FULL_CNT);
    assign rob_empty    = (count == '0);

    // Retire decisions depend only on registered state.
    assign head_rdy    = entries[head].valid && entries[head].done;
    assign norm_retire = head_rdy && !entries[head].exc;
    assign exc_retire  = head_rdy &&  entries[head].exc;
    assign alloc_acc   = alloc_en && !rob_full;
    assign cpl_acc     = cpl_en && entries[cpl_rob_addr].valid &&
                         !(norm_retire && (cpl_rob_addr == head));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i] <= '0;
            end
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            retire_en          <= 1'b0;
            retire_rob_addr    <= '0;
            free_reg_en        <= 1'b0;
            free_reg_addr      <= '0;
            exception_out      <= 1'b0;
            exception_rob_addr <= '0;
        end else begin
            retire_en          <= 1'b0;
            retire_rob_addr    <= '0;
            free_reg_en        <= 1'b0;
            free_reg_addr      <= '0;
            exception_out      <= 1'b0;
            exception_rob_addr <= '0;

            if (flush || exc_retire) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    entries[i].valid <= 1'b0;
                    entries[i].done  <= 1'b0;
                    entries[i].exc   <= 1'b0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
                // A flush already discards the faulting instruction, so it reports nothing and frees nothing.
                if (!flush) begin
                    exception_out      <= 1'b1;
                    exception_rob_addr <= head;
                    free_reg_en        <= entries[head].has_rd;
                    free_reg_addr      <= entries[head].has_rd ? entries[head].new_phy_rd : '0;
                end
            end else begin
                if (norm_retire) begin
                    retire_en              <= 1'b1;
                    retire_rob_addr        <= head;
                    free_reg_en            <= entries[head].has_rd;
                    free_reg_addr          <= entries[head].has_rd ? entries[head].old_phy_rd : '0;
                    entries[head].valid    <= 1'b0;
                    head                   <= head + 1'b1;
                end
                if (cpl_acc) begin
                    entries[cpl_rob_addr].done <= 1'b1;
                    entries[cpl_rob_addr].exc  <= cpl_exception;
                end
                if (alloc_acc) begin
                    entries[tail] <= '{valid:      1'b1,
                                       done:       1'b0,
                                       exc:        1'b0,
                                       has_rd:     alloc_has_rd,
                                       old_phy_rd: alloc_old_phy_rd,
                                       new_phy_rd: alloc_new_phy_rd};
                    tail          <= tail + 1'b1;
                end
                case ({alloc_acc, norm_retire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
